// File: rtl/fir_mac_accum.sv
// Sequential MAC controller around an external signed NxN multiplier: accumulates TAPS products per frame
// and emits one rounded/saturated Q(N-1) result. Define FIR_MAC_ROUND_EN for round-half-up before the shift.
module fir_mac_accum #(
   parameter int N         = 16,
   parameter int TAPS      = 32,
   parameter int GUARD     = 6,
   parameter int OUT_SHIFT = 15,
   localparam int TW       = $clog2(TAPS),
   localparam int ACC_W    = 2*N + GUARD
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [N-1:0]    in_a,
   input  logic [N-1:0]    in_b,
   output logic [N-1:0]    mult_a,
   output logic [N-1:0]    mult_b,
   input  logic [2*N-1:0]  mult_p,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [N-1:0]    out_data,
   output logic            out_sat,
   output logic [TW-1:0]   tap_idx
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ACCUM = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [1:0] OUT   = 2'd3;

   localparam logic signed [ACC_W:0] SMAX = $signed({{(ACC_W-N+2){1'b0}}, {(N-1){1'b1}}});
   localparam logic signed [ACC_W:0] SMIN = ~SMAX;

   logic [1:0]              state;
   logic                    prod_vld, prod_first;
   logic signed [ACC_W-1:0] acc, acc_nxt;
   logic signed [ACC_W:0]   acc_rnd, shifted;
   logic [N-1:0]            res;
   logic                    res_sat;

   wire in_xfer  = in_valid && in_ready;
   wire last_tap = (tap_idx == TW'(TAPS-1));

   // Result is formed from the accumulator value being written this cycle, so the
   // DRAIN edge both folds in the final product and registers the output.
   always_comb begin
      acc_nxt = acc;
      if (prod_vld)
         acc_nxt = prod_first ? ACC_W'($signed(mult_p)) : acc + ACC_W'($signed(mult_p));
`ifdef FIR_MAC_ROUND_EN
      acc_rnd = {acc_nxt[ACC_W-1], acc_nxt} + ((ACC_W+1)'(1) <<< (OUT_SHIFT-1));
`else
      acc_rnd = {acc_nxt[ACC_W-1], acc_nxt};
`endif
      shifted = acc_rnd >>> OUT_SHIFT;
      res     = shifted[N-1:0];
      res_sat = 1'b0;
      if (shifted > SMAX) begin
         res     = {1'b0, {(N-1){1'b1}}};
         res_sat = 1'b1;
      end else if (shifted < SMIN) begin
         res     = {1'b1, {(N-1){1'b0}}};
         res_sat = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         in_ready   <= 1'b0;
         mult_a     <= '0;
         mult_b     <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_sat    <= 1'b0;
         tap_idx    <= '0;
         acc        <= '0;
         prod_vld   <= 1'b0;
         prod_first <= 1'b0;
      end else begin
         prod_vld <= 1'b0;
         if (prod_vld) acc <= acc_nxt;
         if (in_xfer) begin
            mult_a     <= in_a;
            mult_b     <= in_b;
            prod_vld   <= 1'b1;
            prod_first <= (state == IDLE);
         end
         case (state)
            IDLE: begin
               in_ready <= 1'b1;
               if (in_xfer) begin
                  tap_idx <= TW'(1);
                  state   <= ACCUM;
               end
            end
            ACCUM: begin
               if (in_xfer) begin
                  if (last_tap) begin
                     tap_idx  <= '0;
                     in_ready <= 1'b0;
                     state    <= DRAIN;
                  end else begin
                     tap_idx <= tap_idx + TW'(1);
                  end
               end
            end
            DRAIN: begin
               out_valid <= 1'b1;
               out_data  <= res;
               out_sat   <= res_sat;
               state     <= OUT;
            end
            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fir_mac_accum.sv
// Directed bench for fir_mac_accum with a behavioural multiplier on mult_p.
module tb_fir_mac_accum;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready;
   logic [15:0] in_a, in_b, mult_a, mult_b;
   logic [31:0] mult_p;
   logic        out_valid, out_ready, out_sat;
   logic [15:0] out_data;
   logic [4:0]  tap_idx;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   assign mult_p = $signed(mult_a) * $signed(mult_b);

   fir_mac_accum dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .mult_a(mult_a), .mult_b(mult_b), .mult_p(mult_p),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_sat(out_sat), .tap_idx(tap_idx)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Drive cnt pairs (first = a0/b0, rest = ar/br); optional random idle cycles.
   task automatic send_pairs(input int cnt, input logic [15:0] a0, b0, ar, br, input bit gaps);
      int   n = 0;
      int   guard = 0;
      logic rdy;
      while (n < cnt && guard < 1000) begin
         @(negedge clk);
         guard++;
         if (gaps && $urandom_range(0, 2) == 0) in_valid = 1'b0;
         else begin
            in_valid = 1'b1;
            in_a = (n == 0) ? a0 : ar;
            in_b = (n == 0) ? b0 : br;
         end
         rdy = in_ready;
         @(posedge clk);
         if (in_valid && rdy) n++;
      end
      check("send_timeout", 32'(n), 32'(cnt));
   endtask

   // Called right after the last-accept edge; checks latency, hold behaviour and accept.
   task automatic expect_result(input string tag, input logic [15:0] exp_d, input logic exp_s, input int hold);
      @(negedge clk);
      in_valid = 1'b0;
      check({tag, "_drain_vld"}, 32'(out_valid), 32'd0);
      check({tag, "_drain_rdy"}, 32'(in_ready), 32'd0);
      @(negedge clk);
      check({tag, "_vld"}, 32'(out_valid), 32'd1);
      check({tag, "_data"}, 32'(out_data), 32'(exp_d));
      check({tag, "_sat"}, 32'(out_sat), 32'(exp_s));
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1;
         in_a = 16'h7777;
         in_b = 16'h7777;
         @(negedge clk);
         check({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
         check({tag, "_hold_data"}, 32'(out_data), 32'(exp_d));
         check({tag, "_hold_vld"}, 32'(out_valid), 32'd1);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check({tag, "_acc_vld"}, 32'(out_valid), 32'd0);
      check({tag, "_acc_rdy"}, 32'(in_ready), 32'd1);
      check({tag, "_acc_tap"}, 32'(tap_idx), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
      #23;
      check("rst_rdy", 32'(in_ready), 32'd0);
      check("rst_vld", 32'(out_valid), 32'd0);
      check("rst_data", 32'(out_data), 32'd0);
      check("rst_tap", 32'(tap_idx), 32'd0);
      check("rst_ma", 32'(mult_a), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 check("rel_rdy_low", 32'(in_ready), 32'd0);
      @(negedge clk);
      check("rel_rdy_high", 32'(in_ready), 32'd1);

      send_pairs(32, 16'h4000, 16'h4000, 16'h0000, 16'h0000, 1'b0);
      expect_result("impulse", 16'h2000, 1'b0, 0);

      send_pairs(32, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 1'b0);
      expect_result("pos_ovf", 16'h7FFF, 1'b1, 0);

      send_pairs(32, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 1'b0);
      expect_result("neg_ovf", 16'h8000, 1'b1, 0);

      send_pairs(32, 16'h0001, 16'h4000, 16'h0000, 16'h0000, 1'b0);
`ifdef FIR_MAC_ROUND_EN
      expect_result("round", 16'h0001, 1'b0, 0);
`else
      expect_result("round", 16'h0000, 1'b0, 0);
`endif

      send_pairs(32, 16'hC000, 16'h4000, 16'h0000, 16'h0000, 1'b0);
      expect_result("neg_imp", 16'hE000, 1'b0, 0);

      // 32 x (2^8 * 2^9) = 2^22, >>15 = 0x0080
      send_pairs(32, 16'h0100, 16'h0200, 16'h0100, 16'h0200, 1'b1);
      expect_result("gaps", 16'h0080, 1'b0, 10);
      send_pairs(32, 16'h4000, 16'h4000, 16'h0000, 16'h0000, 1'b1);
      expect_result("after_bp", 16'h2000, 1'b0, 0);

      send_pairs(17, 16'h7FFF, 16'h1234, 16'h7FFF, 16'h1234, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      check("mid_ma", 32'(mult_a), 32'h7FFF);
      check("mid_mb", 32'(mult_b), 32'h1234);
      check("mid_tap", 32'(tap_idx), 32'd17);
      @(negedge clk);
      check("gap_tap", 32'(tap_idx), 32'd17);
      rst_n = 1'b0;
      #1;
      check("mrst_tap", 32'(tap_idx), 32'd0);
      check("mrst_rdy", 32'(in_ready), 32'd0);
      check("mrst_ma", 32'(mult_a), 32'd0);
      check("mrst_mb", 32'(mult_b), 32'd0);
      check("mrst_vld", 32'(out_valid), 32'd0);
      check("mrst_sat", 32'(out_sat), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      send_pairs(32, 16'h4000, 16'h4000, 16'h0000, 16'h0000, 1'b0);
      expect_result("post_rst", 16'h2000, 1'b0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
